// File: rtl/alu_issue_if.sv
`default_nettype none
// ============================================================================
// Module      : alu_issue_if
// Description : Bundles the signals of the ALU issue block: the command
//               handshake (cmd_*), the registered operands towards the external
//               combinational ALU (alu_*), the ALU result coming back (alu_out),
//               the result handshake (res_*) and the status outputs
//               (count, busy).
//               master : the environment that feeds commands, provides the
//                        ALU result and consumes results.
//               slave  : the issue block itself.
// Revision    : 1.0 - initial release
// ============================================================================
interface alu_issue_if;
    // Command handshake
    logic       cmd_valid;
    logic       cmd_ready;
    logic [2:0] cmd_op;
    logic [3:0] cmd_a;
    logic [3:0] cmd_b;
    // Operands to the ALU and its combinational result
    logic [3:0] alu_a;
    logic [3:0] alu_b;
    logic [2:0] alu_op;
    logic [3:0] alu_out;
    // Result handshake
    logic       res_valid;
    logic       res_ready;
    logic [3:0] res_data;
    logic [2:0] res_op;
    logic       res_err;
    // Status
    logic [2:0] count;
    logic       busy;

    modport master (
        output cmd_valid, cmd_op, cmd_a, cmd_b, alu_out, res_ready,
        input  cmd_ready, alu_a, alu_b, alu_op,
        input  res_valid, res_data, res_op, res_err, count, busy
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_a, cmd_b, alu_out, res_ready,
        output cmd_ready, alu_a, alu_b, alu_op,
        output res_valid, res_data, res_op, res_err, count, busy
    );
endinterface
`default_nettype wire

// File: rtl/alu_issue.sv
`default_nettype none
// ============================================================================
// Module      : alu_issue
// Description : Four-entry command FIFO in front of an external combinational
//               ALU. Commands {op,a,b} are queued, issued one at a time on the
//               registered alu_* outputs, and the ALU result is captured one
//               cycle later and held on res_* until the consumer accepts it.
//               Op 3'b111 is unsupported: its result is forced to zero and
//               flagged on res_err.
// Ports       : clk  - rising-edge clock
//               rst  - synchronous active-high reset
//               bus  - alu_issue_if.slave (command, ALU, result, status)
// Revision    : 1.0 - initial release
// ============================================================================
module alu_issue #(
    parameter int DEPTH = 4
) (
    input  wire logic  clk,
    input  wire logic  rst,
    alu_issue_if.slave bus
);

    localparam logic [2:0] c_DEPTH  = 3'(DEPTH);
    localparam logic [2:0] c_OP_BAD = 3'b111;

    typedef enum logic [1:0] {
        c_IDLE  = 2'd0,
        c_ISSUE = 2'd1,
        c_HOLD  = 2'd2
    } state_t;

    state_t      state_q,   state_d;
    logic [1:0]  rd_ptr_q,  rd_ptr_d;
    logic [1:0]  wr_ptr_q,  wr_ptr_d;
    logic [2:0]  count_q,   count_d;
    logic [10:0] fifo_q [0:DEPTH-1];
    logic [10:0] fifo_d [0:DEPTH-1];
    logic [3:0]  alu_a_q,   alu_a_d;
    logic [3:0]  alu_b_q,   alu_b_d;
    logic [2:0]  alu_op_q,  alu_op_d;
    logic        res_valid_q, res_valid_d;
    logic [3:0]  res_data_q,  res_data_d;
    logic [2:0]  res_op_q,    res_op_d;
    logic        res_err_q,   res_err_d;

    logic        w_cmd_ready;
    logic        w_push;
    logic        w_pop;

    // Ready depends only on registered occupancy: a pop in the same cycle
    // does not open a slot for a full FIFO.
    assign w_cmd_ready = (count_q < c_DEPTH);
    assign w_push      = bus.cmd_valid && w_cmd_ready;

    always_comb begin
        state_d     = state_q;
        rd_ptr_d    = rd_ptr_q;
        wr_ptr_d    = wr_ptr_q;
        count_d     = count_q;
        fifo_d      = fifo_q;
        alu_a_d     = alu_a_q;
        alu_b_d     = alu_b_q;
        alu_op_d    = alu_op_q;
        res_valid_d = res_valid_q;
        res_data_d  = res_data_q;
        res_op_d    = res_op_q;
        res_err_d   = res_err_q;
        w_pop       = 1'b0;

        // Pops look at the registered count, so a command arriving into an
        // empty FIFO is never popped on the edge that writes it.
        case (state_q)
            c_IDLE: begin
                if (count_q != 3'd0) begin
                    w_pop   = 1'b1;
                    state_d = c_ISSUE;
                end
            end
            c_ISSUE: begin
                res_valid_d = 1'b1;
                res_op_d    = alu_op_q;
                res_err_d   = (alu_op_q == c_OP_BAD);
                res_data_d  = (alu_op_q == c_OP_BAD) ? 4'b0000 : bus.alu_out;
                state_d     = c_HOLD;
            end
            c_HOLD: begin
                if (bus.res_ready) begin
                    res_valid_d = 1'b0;
                    if (count_q != 3'd0) begin
                        w_pop   = 1'b1;
                        state_d = c_ISSUE;
                    end else begin
                        state_d = c_IDLE;
                    end
                end
            end
            default: begin
                state_d = c_IDLE;
            end
        endcase

        if (w_pop) begin
            {alu_op_d, alu_a_d, alu_b_d} = fifo_q[rd_ptr_q];
            rd_ptr_d = rd_ptr_q + 2'd1;
        end

        if (w_push) begin
            fifo_d[wr_ptr_q] = {bus.cmd_op, bus.cmd_a, bus.cmd_b};
            wr_ptr_d = wr_ptr_q + 2'd1;
        end

        case ({w_push, w_pop})
            2'b10:   count_d = count_q + 3'd1;
            2'b01:   count_d = count_q - 3'd1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= c_IDLE;
            rd_ptr_q    <= 2'd0;
            wr_ptr_q    <= 2'd0;
            count_q     <= 3'd0;
            alu_a_q     <= 4'b0000;
            alu_b_q     <= 4'b0000;
            alu_op_q    <= 3'b000;
            res_valid_q <= 1'b0;
            res_data_q  <= 4'b0000;
            res_op_q    <= 3'b000;
            res_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            rd_ptr_q    <= rd_ptr_d;
            wr_ptr_q    <= wr_ptr_d;
            count_q     <= count_d;
            alu_a_q     <= alu_a_d;
            alu_b_q     <= alu_b_d;
            alu_op_q    <= alu_op_d;
            res_valid_q <= res_valid_d;
            res_data_q  <= res_data_d;
            res_op_q    <= res_op_d;
            res_err_q   <= res_err_d;
        end
    end

    // Storage needs no reset: entries are only read after being written.
    always_ff @(posedge clk) begin
        fifo_q <= fifo_d;
    end

    assign bus.cmd_ready = w_cmd_ready;
    assign bus.alu_a     = alu_a_q;
    assign bus.alu_b     = alu_b_q;
    assign bus.alu_op    = alu_op_q;
    assign bus.res_valid = res_valid_q;
    assign bus.res_data  = res_data_q;
    assign bus.res_op    = res_op_q;
    assign bus.res_err   = res_err_q;
    assign bus.count     = count_q;
    assign bus.busy      = (state_q != c_IDLE) || (count_q != 3'd0);

endmodule
`default_nettype wire

// File: tb/tb_alu_issue.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_issue
// Description : Self-checking bench for alu_issue. A transaction-level model
//               (queue of accepted commands plus the one command in flight)
//               predicts every output each cycle; directed scenarios add
//               hand-computed literal expectations. ALU model: a ^ b.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_issue;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    alu_issue_if bus ();

    alu_issue #(.DEPTH(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    assign bus.alu_out = bus.alu_a ^ bus.alu_b;

    int vectors    = 0;
    int miscompares = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic timeout(input string name);
        vectors++;
        miscompares++;
        $display("FAIL %s: timed out at %0t", name, $time);
    endtask

    // ---------------- transaction-level model ----------------
    bit          m_ok = 1'b0;
    logic [10:0] mq[$];           // accepted, not yet issued {op,a,b}
    int          m_phase = 0;     // 0 nothing in flight, 1 issuing, 2 result held
    logic [10:0] m_cur;
    logic [3:0]  m_alu_a, m_alu_b, m_res_data;
    logic [2:0]  m_alu_op, m_res_op;
    logic        m_res_err;

    always @(posedge clk) begin
        bit acc;
        if (rst) begin
            mq.delete();
            m_phase = 0;
            m_alu_a = 0; m_alu_b = 0; m_alu_op = 0;
            m_res_data = 0; m_res_op = 0; m_res_err = 0;
            m_ok = 1'b1;
        end else if (m_ok) begin
            acc = bus.cmd_valid && (mq.size() < 4);
            if (m_phase == 0) begin
                if (mq.size() > 0) begin
                    m_cur = mq.pop_front();
                    {m_alu_op, m_alu_a, m_alu_b} = m_cur;
                    m_phase = 1;
                end
            end else if (m_phase == 1) begin
                m_res_op   = m_alu_op;
                m_res_err  = (m_alu_op == 3'b111);
                m_res_data = (m_alu_op == 3'b111) ? 4'b0000 : (m_alu_a ^ m_alu_b);
                m_phase    = 2;
            end else if (bus.res_ready) begin
                if (mq.size() > 0) begin
                    m_cur = mq.pop_front();
                    {m_alu_op, m_alu_a, m_alu_b} = m_cur;
                    m_phase = 1;
                end else begin
                    m_phase = 0;
                end
            end
            if (acc) mq.push_back({bus.cmd_op, bus.cmd_a, bus.cmd_b});
        end
    end

    always @(negedge clk) begin
        if (m_ok) begin
            chk("count",     bus.count,     mq.size());
            chk("cmd_ready", bus.cmd_ready, mq.size() < 4);
            chk("busy",      bus.busy,      (m_phase != 0) || (mq.size() != 0));
            chk("res_valid", bus.res_valid, m_phase == 2);
            chk("alu_a",     bus.alu_a,     m_alu_a);
            chk("alu_b",     bus.alu_b,     m_alu_b);
            chk("alu_op",    bus.alu_op,    m_alu_op);
            if (m_phase == 2) begin
                chk("res_data", bus.res_data, m_res_data);
                chk("res_op",   bus.res_op,   m_res_op);
                chk("res_err",  bus.res_err,  m_res_err);
            end
        end
    end

    // ---------------- result log and helpers ----------------
    logic [7:0] got_q[$];         // {op, err, data} of every accepted result
    always @(negedge clk) begin
        if (!rst && bus.res_valid === 1'b1 && bus.res_ready === 1'b1)
            got_q.push_back({bus.res_op, bus.res_err, bus.res_data});
    end

    bit toggle_en = 1'b0;
    always @(posedge clk) begin
        if (toggle_en) begin
            #1;
            bus.res_ready = ~bus.res_ready;
        end
    end

    bit track_en = 1'b0;
    int max_cnt  = 0;
    always @(negedge clk) begin
        if (track_en && int'(bus.count) > max_cnt) max_cnt = int'(bus.count);
    end

    // Called and returns just after a rising edge.
    task automatic push(input logic [2:0] op, input logic [3:0] a, input logic [3:0] b);
        bit acc = 1'b0;
        int n   = 0;
        bus.cmd_valid = 1'b1;
        bus.cmd_op = op; bus.cmd_a = a; bus.cmd_b = b;
        while (!acc && n < 200) begin
            @(negedge clk);
            acc = bus.cmd_ready;
            @(posedge clk);
            #1;
            n++;
        end
        bus.cmd_valid = 1'b0;
        if (!acc) timeout("push");
    endtask

    task automatic wait_results(input int n);
        int k = 0;
        while (got_q.size() < n && k < 400) begin
            @(negedge clk);
            k++;
        end
        if (got_q.size() < n) timeout("wait_results");
    endtask

    task automatic wait_idle();
        int k = 0;
        do begin
            @(posedge clk);
            #1;
            k++;
        end while (bus.busy !== 1'b0 && k < 400);
        if (bus.busy !== 1'b0) timeout("wait_idle");
    endtask

    // ---------------- directed scenarios ----------------
    initial begin
        logic [7:0] e;
        bus.cmd_valid = 1'b0;
        bus.cmd_op = 3'd0; bus.cmd_a = 4'd0; bus.cmd_b = 4'd0;
        bus.res_ready = 1'b0;

        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_count", bus.count, 0);
        chk("rst_cmd_ready", bus.cmd_ready, 1);
        chk("rst_busy", bus.busy, 0);
        chk("rst_res_valid", bus.res_valid, 0);
        chk("rst_alu_a", bus.alu_a, 0);
        chk("rst_res_data", bus.res_data, 0);
        rst = 1'b0;
        bus.res_ready = 1'b1;

        // Single command latency: push at edge 1, issue at 2, result at 3.
        bus.cmd_valid = 1'b1;
        bus.cmd_op = 3'b000; bus.cmd_a = 4'b0011; bus.cmd_b = 4'b0010;
        @(posedge clk); #1;
        bus.cmd_valid = 1'b0;
        chk("lat_count_e1", bus.count, 1);
        @(posedge clk); #1;
        chk("lat_alu_a_e2", bus.alu_a, 4'b0011);
        chk("lat_alu_b_e2", bus.alu_b, 4'b0010);
        chk("lat_res_valid_e2", bus.res_valid, 0);
        @(posedge clk); #1;
        chk("lat_res_valid_e3", bus.res_valid, 1);
        chk("lat_res_data_e3", bus.res_data, 4'b0001);
        chk("lat_res_op_e3", bus.res_op, 0);
        chk("lat_res_err_e3", bus.res_err, 0);
        @(posedge clk); #1;
        chk("lat_busy_e4", bus.busy, 0);

        // Back-pressure: seven ops, consumer stalled until the FIFO is full.
        bus.res_ready = 1'b0;
        got_q.delete();
        fork
            begin
                for (int i = 0; i < 7; i++) push(3'(i), 4'b0011, 4'b0010);
            end
            begin
                repeat (7) @(posedge clk);
                #1;
                chk("full_cmd_ready", bus.cmd_ready, 0);
                chk("full_count", bus.count, 4);
                bus.res_ready = 1'b1;
            end
        join
        wait_results(7);
        for (int i = 0; i < 7 && i < got_q.size(); i++) begin
            e = got_q[i];
            chk("order_op", e[7:5], i);
            chk("order_data", e[3:0], 4'b0001);
        end
        wait_idle();

        // Unsupported op.
        got_q.delete();
        push(3'b111, 4'b1111, 4'b0000);
        wait_results(1);
        if (got_q.size() > 0) begin
            e = got_q[0];
            chk("bad_data", e[3:0], 4'b0000);
            chk("bad_err", e[4], 1);
            chk("bad_op", e[7:5], 3'b111);
        end
        wait_idle();

        // Pointer wrap with toggling consumer.
        got_q.delete();
        max_cnt = 0;
        track_en = 1'b1;
        toggle_en = 1'b1;
        for (int i = 0; i < 10; i++) push(3'b000, 4'(i), 4'b0000);
        wait_results(10);
        toggle_en = 1'b0;
        track_en = 1'b0;
        @(posedge clk); #2;
        bus.res_ready = 1'b1;
        for (int i = 0; i < 10 && i < got_q.size(); i++) begin
            e = got_q[i];
            chk("wrap_data", e[3:0], i);
        end
        chk("wrap_max_count_le4", max_cnt <= 4, 1);
        wait_idle();

        // Reset while holding a result with three queued.
        got_q.delete();
        bus.res_ready = 1'b0;
        for (int i = 0; i < 4; i++) push(3'b000, 4'(i + 1), 4'b0000);
        chk("pre_rst_count", bus.count, 3);
        chk("pre_rst_res_valid", bus.res_valid, 1);
        bus.cmd_valid = 1'b1;
        bus.cmd_op = 3'b001; bus.cmd_a = 4'b0101; bus.cmd_b = 4'b0000;
        rst = 1'b1;
        @(posedge clk); #1;
        chk("mid_rst_res_valid", bus.res_valid, 0);
        chk("mid_rst_count", bus.count, 0);
        chk("mid_rst_cmd_ready", bus.cmd_ready, 1);
        rst = 1'b0;
        bus.cmd_valid = 1'b0;
        bus.res_ready = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        chk("no_stale_results", got_q.size(), 0);
        chk("post_rst_busy", bus.busy, 0);

        // Full FIFO, producer held, pop in the same cycle: no push.
        got_q.delete();
        bus.res_ready = 1'b0;
        for (int i = 0; i < 5; i++) push(3'b000, 4'(i), 4'b0000);
        chk("fp_count_full", bus.count, 4);
        bus.cmd_valid = 1'b1;
        bus.cmd_op = 3'b000; bus.cmd_a = 4'd9; bus.cmd_b = 4'd0;
        bus.res_ready = 1'b1;
        @(posedge clk); #1;
        chk("fp_count_after_pop", bus.count, 3);
        bus.res_ready = 1'b0;
        @(posedge clk); #1;
        chk("fp_count_after_push", bus.count, 4);
        bus.cmd_valid = 1'b0;
        bus.res_ready = 1'b1;
        wait_results(6);
        for (int i = 0; i < 6 && i < got_q.size(); i++) begin
            e = got_q[i];
            chk("fp_data", e[3:0], (i == 5) ? 9 : i);
        end
        wait_idle();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
